// File: rtl/branch_encode.sv
// branch_encode: two-stage pipelined encoder from decoded branch fields to RV32 instruction words
module branch_encode #(
    parameter int ERR_CNT_W   = 8,
    parameter bit DROP_ON_ERR = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 is_nop,
    input  logic                 is_jmp,
    input  logic                 is_imm_type,
    input  logic                 zero_ext,
    input  logic [1:0]           op,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [4:0]           rd,
    input  logic [19:0]          imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          inst,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);
    logic        s1_valid, s1_nop, s1_jmp, s1_imm_type, s1_zero_ext;
    logic [1:0]  s1_op;
    logic [4:0]  s1_rs1, s1_rs2, s1_rd;
    logic [19:0] s1_imm;
    logic        s2_can_take, imm_ok, err;
    logic [2:0]  funct3;
    logic [31:0] br_inst, jal_inst, jalr_inst, enc;

    assign s2_can_take = !out_valid || out_ready;
    assign in_ready    = !s1_valid || s2_can_take;

    // build every candidate format from stage 1 and decide legality; illegal entries encode as zero
    always_comb begin
        imm_ok    = &s1_imm[19:11] || ~|s1_imm[19:11];
        funct3    = {s1_op[1], s1_op[1] & s1_zero_ext, s1_op[0]};
        br_inst   = {s1_imm[11], s1_imm[9:4], s1_rs2, s1_rs1, funct3, s1_imm[3:0], s1_imm[10], 7'b1100011};
        jal_inst  = {s1_imm[19], s1_imm[9:0], s1_imm[10], s1_imm[18:11], s1_rd, 7'b1101111};
        jalr_inst = {s1_imm[11:0], s1_rs1, 3'b000, s1_rd, 7'b1100111};
        err       = !s1_nop && (s1_jmp ? (s1_imm_type && !imm_ok)
                                       : (s1_imm_type || !imm_ok || (s1_zero_ext && !s1_op[1])));
        enc       = (s1_nop || err) ? '0 : s1_jmp ? (s1_imm_type ? jalr_inst : jal_inst) : br_inst;
    end

    // stage 1 occupancy: refills whenever the stage can advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) s1_valid <= 1'b0;
        else if (in_ready) s1_valid <= in_valid;
    end

    // stage 1 payload: captured only on an accepted handshake
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_nop      <= is_nop;
            s1_jmp      <= is_jmp;
            s1_imm_type <= is_imm_type;
            s1_zero_ext <= zero_ext;
            s1_op       <= op;
            s1_rs1      <= rs1;
            s1_rs2      <= rs2;
            s1_rd       <= rd;
            s1_imm      <= imm;
        end
    end

    // stage 2: registered outputs held while stalled; errors counted on entry with saturation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            inst      <= '0;
            out_err   <= 1'b0;
            err_count <= '0;
        end else if (s2_can_take) begin
            out_valid <= s1_valid && !(DROP_ON_ERR && err);
            if (s1_valid) begin
                inst    <= enc;
                out_err <= err;
                if (err && !(&err_count)) err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end
endmodule

// File: doc/branch_encode.md
Name: branch_encode

Overview:
- Pipelined encoder for the branch slot. It is the inverse of the branch decode stage.
- Accepts decoded branch fields (nop / conditional branch / JAL / JALR) and assembles the 32-bit RV32 instruction word.
- Used by the bundle builder and the test-vector generator to emit branch-slot instructions.
- Two-stage valid/ready pipeline with backpressure, field-legality checking and a saturating error counter.

Parameters:
- ERR_CNT_W, 8, width of the saturating error counter.
- DROP_ON_ERR, 0, if 1 errored entries are consumed and counted but never presented on the output.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  input fields valid
- in_ready  output  1  encoder can accept this cycle
- is_nop  input  1  emit NOP (highest priority)
- is_jmp  input  1  JAL/JALR select
- is_imm_type  input  1  with is_jmp: JALR
- zero_ext  input  1  unsigned compare (BLTU/BGEU)
- op  input  2  00 EQ, 01 NE, 10 LT, 11 GE
- rs1  input  5  source 1
- rs2  input  5  source 2
- rd  input  5  destination (jumps)
- imm  input  20  immediate, same layout as decode output
- out_valid  output  1  inst valid
- out_ready  input  1  consumer accepts
- inst  output  32  encoded instruction
- out_err  output  1  entry was illegal; inst forced to 0
- err_count  output  ERR_CNT_W  saturating count of illegal entries

Behaviour:
- Reset values: in_ready=1, out_valid=0, inst=0, out_err=0, err_count=0. Reset mid-operation flushes both stages; in-flight entries are lost.
- Stage 1 registers the input fields on in_valid&&in_ready. Stage 2 registers the assembled inst and out_err.
- Latency: accepted in cycle N appears with out_valid in cycle N+2 when there are no stalls.
- Throughput: 1 per cycle.
- Stage advance rule: a stage advances when it is empty or its downstream accepts.
- in_ready = !s1_valid || s2_can_take, where s2_can_take = !out_valid || out_ready.
- Ordering is strictly preserved.
- Handshake: inst, out_err and out_valid are held stable while out_valid && !out_ready.
- Class priority:
  - is_nop: inst=0.
  - else is_jmp&&is_imm_type: JALR.
  - else is_jmp: JAL.
  - else is_imm_type=1: illegal.
  - else: conditional branch.
- Branch encoding:
  - opcode 1100011; rs1->[19:15]; rs2->[24:20].
  - funct3 by op: 00->000, 01->001, 10->(zero_ext?110:100), 11->(zero_ext?111:101).
  - zero_ext=1 with op 00/01: illegal.
  - imm[11]->[31], imm[10]->[7], imm[9:4]->[30:25], imm[3:0]->[11:8].
  - imm[19:11] not all equal: illegal.
- JAL encoding:
  - opcode 1101111; rd->[11:7].
  - imm[19]->[31], imm[18:11]->[19:12], imm[10]->[20], imm[9:0]->[30:21].
  - rs1, rs2, zero_ext and op are ignored.
- JALR encoding:
  - opcode 1100111; funct3 000; rd->[11:7]; rs1->[19:15].
  - imm[11]->[31], imm[10:0]->[30:20].
  - imm[19:11] not all equal: illegal.
- Illegal entry handling:
  - Stage 2 holds inst=0, out_err=1.
  - err_count increments by 1 when the entry is registered into stage 2, saturating at all-ones.
  - With DROP_ON_ERR=1, the entry is counted but out_valid stays 0 for it. It consumes a pipeline slot without stalling.
- Simultaneous accept-in and drain-out on a full pipeline is legal: full throughput, no bubble.

Test Plan:
- Reset check: rst pulse, then idle -> in_ready=1, out_valid=0, inst=0, err_count=0.
- Conditional branches, out_ready=1:
  - BEQ: op=00, rs1=1, rs2=2, imm=20'h00008 -> inst=32'h00208863 two cycles later, out_err=0.
  - BLTU: op=10, zero_ext=1, rs1=3, rs2=4, imm=20'hFFFFF -> inst=32'hFE41EFE3.
- Jumps, back-to-back in consecutive cycles:
  - JAL: is_jmp=1, rd=1, imm=20'h00002 -> 32'h004000EF.
  - JALR: is_imm_type=1, rd=0, rs1=1, imm=0 -> 32'h00008067.
  - NOP: is_nop=1 with other fields random -> 32'h00000000.
  - Outputs appear in order on consecutive cycles.
- Illegal entries:
  - Branch imm=20'h00800 -> out_valid=1, out_err=1, inst=0, err_count=1.
  - Branch op=00, zero_ext=1 -> err_count=2.
  - With DROP_ON_ERR=1, the same stimulus gives no out_valid and err_count=2.
- Backpressure:
  - out_ready=0, offer 3 valid entries -> 2 accepted, then in_ready=0; inst stable while stalled.
  - Release out_ready -> all 3 delivered in order, none duplicated.
- Reset mid-operation: assert rst with both stages full -> out_valid=0 immediately (async), in_ready=1 after release, no stale entry emitted afterward.
